// File: rtl/poly_eval_seq.sv
// poly_eval_seq: sequential Horner evaluator for an unsigned polynomial of
// degree DEGREE. One multiply-add per clock; result is held after completion
// and ovf records whether any intermediate step needed more than W bits.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; inputs latched on the accepting edge
// CALC  | one Horner step per clock, cnt counts down to zero
// DONE  | one-cycle done pulse, result valid; start ignored here
module poly_eval_seq #(
   parameter int W      = 16,
   parameter int XW     = 8,
   parameter int DEGREE = 2
) (
   input  logic                      ck,
   input  logic                      rst,
   input  logic                      start,
   input  logic [XW-1:0]             x,
   input  logic [(DEGREE+1)*W-1:0]   coef,
   output logic                      busy,
   output logic                      done,
   output logic [W-1:0]              result,
   output logic                      ovf
);

   localparam int CW = (DEGREE < 2) ? 1 : $clog2(DEGREE + 1);
   // Wide enough that acc*x + c can never wrap, so the upper bits are exact.
   localparam int FW = W + XW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [W-1:0]            acc;
   logic [XW-1:0]           x_reg;
   logic [(DEGREE+1)*W-1:0] coef_reg;
   logic [W-1:0]            c_next;
   logic [FW-1:0]           full;

   // Select c[cnt-1] from the latched coefficients and form the full-width step.
   always_comb begin
      c_next = '0;
      for (int i = 0; i < DEGREE; i++) begin
         if (cnt == CW'(i + 1)) begin
            c_next = coef_reg[i*W +: W];
         end
      end
      full = FW'(acc) * FW'(x_reg) + FW'(c_next);
   end

   // Control FSM and datapath registers, all outputs registered.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         x_reg    <= '0;
         coef_reg <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  x_reg    <= x;
                  coef_reg <= coef;
                  acc      <= coef[DEGREE*W +: W];
                  cnt      <= CW'(DEGREE);
                  ovf      <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc <= full[W-1:0];
               cnt <= cnt - 1'b1;
               if (|full[FW-1:W]) begin
                  ovf <= 1'b1;
               end
               if (cnt == CW'(1)) begin
                  result <= full[W-1:0];
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_poly_eval_seq.sv
// Directed bench for poly_eval_seq: a DEGREE=2 instance for most cases and a
// DEGREE=4 instance for the longer polynomial.
module tb_poly_eval_seq;

   logic        ck;
   logic        rst;

   logic        start;
   logic [7:0]  x;
   logic [47:0] coef;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        ovf;

   logic        start4;
   logic [7:0]  x4;
   logic [79:0] coef4;
   logic        busy4;
   logic        done4;
   logic [15:0] result4;
   logic        ovf4;

   int checks = 0;
   int passes = 0;

   poly_eval_seq #(.W(16), .XW(8), .DEGREE(2)) u_dut (
      .ck(ck), .rst(rst), .start(start), .x(x), .coef(coef),
      .busy(busy), .done(done), .result(result), .ovf(ovf)
   );

   poly_eval_seq #(.W(16), .XW(8), .DEGREE(4)) u_dut4 (
      .ck(ck), .rst(rst), .start(start4), .x(x4), .coef(coef4),
      .busy(busy4), .done(done4), .result(result4), .ovf(ovf4)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Start one DEGREE=2 evaluation; returns result, ovf, edges to done, busy cycles.
   task automatic run2(input logic [7:0] xv, input logic [15:0] c2, input logic [15:0] c1,
                       input logic [15:0] c0, output logic [15:0] res, output logic ov,
                       output int lat, output int nbusy);
      @(negedge ck);
      x = xv; coef = {c2, c1, c0}; start = 1'b1;
      @(negedge ck);
      start = 1'b0;
      lat = 0; nbusy = 0;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         @(negedge ck);
         lat++;
      end
      res = result; ov = ovf;
   endtask

   logic [15:0] r;
   logic        o;
   int          lat, nb, ndone, first_at, second_at;
   logic [15:0] first_res, second_res;

   initial begin
      rst = 1'b0; start = 1'b0; x = '0; coef = '0;
      start4 = 1'b0; x4 = '0; coef4 = '0;
      #12;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_result", result, 0);
      chk("reset_ovf", ovf, 0);
      @(negedge ck); rst = 1'b1;
      repeat (2) @(negedge ck);

      // Case 1: 2*9 + 5*3 + 7 = 40
      run2(8'd3, 16'd2, 16'd5, 16'd7, r, o, lat, nb);
      chk("c1_latency", lat, 2);
      chk("c1_busy_cycles", nb, 2);
      chk("c1_result", r, 16'd40);
      chk("c1_ovf", o, 0);
      chk("c1_busy_at_done", busy, 0);
      @(negedge ck);
      chk("c1_done_one_cycle", done, 0);

      // Case 2: second step is 0x10005, wraps to 5 with overflow
      run2(8'h10, 16'h0100, 16'h0000, 16'h0005, r, o, lat, nb);
      chk("c2_result", r, 16'h0005);
      chk("c2_ovf", o, 1);
      run2(8'd1, 16'd1, 16'd1, 16'd1, r, o, lat, nb);
      chk("c2b_result", r, 16'd3);
      chk("c2b_ovf_cleared", o, 0);

      // Case 3: start held high, inputs changed after acceptance
      @(negedge ck);
      x = 8'd3; coef = {16'd2, 16'd5, 16'd7}; start = 1'b1;
      ndone = 0; first_at = -1; second_at = -1; first_res = '0; second_res = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge ck);
         if (i == 0) begin
            x = 8'd5; coef = {16'd1, 16'd1, 16'd1};
         end
         if (done) begin
            ndone++;
            if (first_at < 0) begin
               first_at = i; first_res = result;
            end else begin
               second_at = i; second_res = result;
            end
         end
      end
      start = 1'b0;
      chk("c3_done_count", ndone, 2);
      chk("c3_first_at", first_at, 2);
      chk("c3_first_result", first_res, 16'd40);
      chk("c3_second_at", second_at, 6);
      chk("c3_second_result", second_res, 16'd31);
      repeat (3) @(negedge ck);

      // Case 4: asynchronous reset in CALC after an overflowing step
      @(negedge ck);
      x = 8'hFF; coef = {16'hABCD, 16'hFFFF, 16'h1234}; start = 1'b1;
      @(negedge ck);
      start = 1'b0;
      @(posedge ck);
      #2;
      chk("c4_pre_busy", busy, 1);
      chk("c4_pre_ovf", ovf, 1);
      rst = 1'b0;
      #1;
      chk("c4_rst_busy", busy, 0);
      chk("c4_rst_done", done, 0);
      chk("c4_rst_result", result, 0);
      chk("c4_rst_ovf", ovf, 0);
      @(negedge ck); rst = 1'b1;
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge ck);
         if (done || busy) ndone++;
      end
      chk("c4_no_done_after_rst", ndone, 0);
      run2(8'd3, 16'd2, 16'd5, 16'd7, r, o, lat, nb);
      chk("c4_after_rst_result", r, 16'd40);
      chk("c4_after_rst_latency", lat, 2);

      // Case 5: DEGREE=4, x=2, all ones -> 31
      @(negedge ck);
      x4 = 8'd2; coef4 = {5{16'd1}}; start4 = 1'b1;
      @(negedge ck);
      start4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 20) begin
         @(negedge ck);
         lat++;
      end
      chk("c5_latency", lat, 4);
      chk("c5_result", result4, 16'h001F);
      chk("c5_ovf", ovf4, 0);

      // Case 6: wrap with overflow, then hold across idle cycles
      run2(8'hFF, 16'hABCD, 16'hFFFF, 16'h1234, r, o, lat, nb);
      chk("c6_result", r, 16'h2302);
      chk("c6_ovf", o, 1);
      repeat (10) @(negedge ck);
      chk("c6_hold_result", result, 16'h2302);
      chk("c6_hold_ovf", ovf, 1);

      // Edge cases: x=0 gives c0; all-zero coefficients give 0 without overflow
      run2(8'd0, 16'hFFFF, 16'hFFFF, 16'h0042, r, o, lat, nb);
      chk("x0_result", r, 16'h0042);
      run2(8'hFF, 16'd0, 16'd0, 16'd0, r, o, lat, nb);
      chk("zero_coef_result", r, 16'd0);
      chk("zero_coef_ovf", o, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, passed %0d of %0d", passes, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/poly_eval_seq.md
Name: poly_eval_seq

Overview:
- Parametrised sequential polynomial evaluator: computes P(X) = c[DEGREE]*X^DEGREE + ... + c[1]*X + c[0] using Horner's method, one multiply-add per clock.
- Successor to the fixed A*X^2 + B*X + C control/datapath pair.
- Generalises coefficient width, X width and polynomial degree.
- Adds a start/busy/done handshake, an output register that holds its value, and a sticky overflow flag.
- Sits between the stimulus/top level and any consumer of the result.

Parameters:
- W, 16, coefficient and result width in bits.
- XW, 8, width of the input variable X.
- DEGREE, 2, polynomial degree. Must be ≥ 1.

Ports:
- ck  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- start  input  1  request pulse. Sampled only in IDLE.
- x  input  XW  variable X. Unsigned. Sampled on the accepted start.
- coef  input  (DEGREE+1)*W  packed coefficients. coef[(i+1)*W-1 : i*W] is the coefficient of X^i. Unsigned. Sampled on the accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; result is valid.
- result  output  W  P(X) mod 2^W. Held until the next completion.
- ovf  output  1  sticky; set if any Horner step exceeded W bits.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - State = IDLE.
  - busy = 0, done = 0, result = 0, ovf = 0.
  - acc, x_reg, cnt and coef_reg are cleared.
  - A reset during CALC aborts the evaluation; no done pulse is emitted.
- States: IDLE, CALC, DONE.
- IDLE:
  - busy = 0, done = 0.
  - On start=1 at a rising edge:
    - x_reg <= x.
    - coef_reg <= coef.
    - acc <= c[DEGREE].
    - cnt <= DEGREE.
    - ovf <= 0.
    - Go to CALC.
- CALC:
  - busy = 1.
  - On each edge: acc <= (acc*x_reg + c[cnt-1]) truncated to W bits, and cnt <= cnt-1.
  - Full-width value: compute at W+XW+1 bits. If any bit above W-1 is nonzero, set ovf <= 1. ovf stays set until the next accepted start.
  - The edge that makes cnt = 0 also writes result <= new acc and moves to DONE.
  - CALC therefore lasts exactly DEGREE cycles.
- DONE:
  - done = 1 for exactly one cycle, busy = 0.
  - Next edge returns to IDLE.
  - start is ignored in DONE; it is accepted from IDLE only, at the earliest one cycle later.
- Latency: for a start sampled at edge k, done is high in the cycle after edge k+DEGREE. Back-to-back throughput is one evaluation per DEGREE+2 cycles.
- start while busy or in DONE: ignored. Inputs are not resampled and the evaluation in flight is unaffected.
- x and coef may change freely after the accepted start; only the latched copies are used.
- result and ovf are stable from DONE until the next completion or reset. They do not change during a new CALC, except that ovf clears at the accepted start.
- Arithmetic is unsigned; wrap-around is mod 2^W.
- Edge cases:
  - x = 0 gives result = c[0].
  - All-zero coefficients give result = 0, ovf = 0.

Test Plan:
1. W=16, XW=8, DEGREE=2. x=3, c2=2, c1=5, c0=7, start pulse at edge k.
   -> busy high for 2 cycles; done high in the cycle after edge k+2; result=0x0028 (40); ovf=0.
2. DEGREE=2, x=0x10, c2=0x0100, c1=0, c0=5.
   -> Step 1 acc=0x1000. Step 2 full value is 0x10005, truncated to 0x0005.
   -> result=0x0005, ovf=1.
   -> A following start with x=1, c=1,1,1 gives result=3 and ovf cleared to 0.
3. Start asserted continuously during CALC and DONE, with x and coef changed mid-run.
   -> First result is unaffected (40 for case 1 data).
   -> Second evaluation begins only after return to IDLE; exactly one done pulse per accepted start.
4. rst driven low asynchronously (between clock edges) during CALC.
   -> busy, done, result, ovf go to 0 immediately; state IDLE; no done pulse after release.
   -> A new start after rst returns to 1 evaluates correctly.
5. DEGREE=4, W=16, x=2, all coefficients 1.
   -> done in the cycle after edge k+4; result=31 (0x001F); ovf=0.
6. x=0xFF, c=0x1234,0xFFFF,0xABCD (DEGREE=2).
   -> result equals 0x1234 + 0xFFFF*0xFF + 0xABCD*0xFF^2, reduced mod 2^16; ovf=1.
   -> result holds across 10 idle cycles.
